// File: rtl/ula_pkg.sv
// ula_pkg - shared types and constants for the ALU result to BCD converter.
//   state_t    : converter FSM states (IDLE, SHIFT, LOAD)
//   BCD_W      : width of one BCD digit
//   ADJ_THRESH : digit value at or above which the shift-and-add-3 step applies
//   ADJ_ADD    : amount added to a digit before the shift
//   DEF_MAG_W  : default magnitude width of the ALU result word
//   POS_BIT    : bit index of the positive flag in the default result word
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam int BCD_W      = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_ADD    = 3;
    localparam int DEF_MAG_W  = 8;
    localparam int POS_BIT    = DEF_MAG_W;

endpackage

// File: rtl/bcd_adjust_digit.sv
// bcd_adjust_digit - one digit of the double-dabble correction step.
//   digit_i : BCD digit before the shift
//   digit_o : digit + 3 when digit_i >= 5, otherwise digit_i unchanged
// Purely combinational. Adding 3 ahead of the left shift is what makes a
// digit of 5..9 carry correctly into the next digit after doubling.
module bcd_adjust_digit
    import ula_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);

    assign digit_o = (digit_i >= BCD_W'(ADJ_THRESH)) ? digit_i + BCD_W'(ADJ_ADD)
                                                     : digit_i;

endmodule

// File: rtl/ula_result_bcd.sv
// ula_result_bcd - converts the signed-magnitude ALU result into a sign flag
// plus three BCD digits for the seven-segment display.
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : conversion request, only honoured while idle
//   r        : ALU result, r[MAG_W] = positive flag, r[MAG_W-1:0] = magnitude
//   busy     : high while a conversion is in progress (decoded from state)
//   done     : one-cycle pulse when neg/hundreds/tens/ones have been updated
//   neg      : 1 = display a minus sign
//   hundreds : BCD digit 2
//   tens     : BCD digit 1
//   ones     : BCD digit 0
// Conversion is sequential shift-and-add-3: one capture edge, MAG_W shift
// edges, then one load edge that publishes the result.
module ula_result_bcd
    import ula_pkg::*;
#(
    parameter int MAG_W  = DEF_MAG_W,
    parameter int DIGITS = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [MAG_W:0]   r,
    output logic             busy,
    output logic             done,
    output logic             neg,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    localparam int ACC_W = DIGITS * BCD_W;
    localparam int SH_W  = ACC_W + MAG_W;
    localparam int CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;

    state_t             state_q;
    logic [MAG_W-1:0]   mag_q;
    logic               neg_cap_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;
    logic               neg_q;
    logic [BCD_W-1:0]   hundreds_q;
    logic [BCD_W-1:0]   tens_q;
    logic [BCD_W-1:0]   ones_q;

    // Correct every digit first, then shift the combined {bcd, magnitude}
    // word left by one. The MSB falling off the top is always zero because
    // 10^DIGITS exceeds the largest magnitude.
    logic [ACC_W-1:0]   acc_adj;
    logic [SH_W-1:0]    shift_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adjust_digit u_adj (
            .digit_i (acc_q[g*BCD_W +: BCD_W]),
            .digit_o (acc_adj[g*BCD_W +: BCD_W])
        );
    end

    assign shift_d = {acc_adj, mag_q} << 1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            neg_cap_q  <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            neg_q      <= 1'b0;
            hundreds_q <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mag_q     <= r[MAG_W-1:0];
                        // Negative zero is shown as plain zero.
                        neg_cap_q <= ~r[MAG_W] & (|r[MAG_W-1:0]);
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= shift_d[SH_W-1 -: ACC_W];
                    mag_q <= shift_d[MAG_W-1:0];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MAG_W - 1)) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    hundreds_q <= acc_q[2*BCD_W +: BCD_W];
                    tens_q     <= acc_q[1*BCD_W +: BCD_W];
                    ones_q     <= acc_q[0*BCD_W +: BCD_W];
                    neg_q      <= neg_cap_q;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign neg      = neg_q;
    assign hundreds = hundreds_q;
    assign tens     = tens_q;
    assign ones     = ones_q;

endmodule

// File: tb/tb_ula_result_bcd.sv
// tb_ula_result_bcd - self-checking bench for ula_result_bcd.
// Expected results are pushed to a scoreboard queue when a conversion is
// started and popped by a monitor when done pulses.
module tb_ula_result_bcd;

    typedef struct {
        logic [8:0] r;
        logic       neg;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } vec_t;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [8:0] r;
    logic       busy;
    logic       done;
    logic       neg;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    vec_t sb[$];

    ula_result_bcd dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .neg      (neg),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Independent arithmetic model of the display value.
    function automatic vec_t model(input logic [8:0] rv);
        vec_t e;
        int   m;
        m     = int'(rv[7:0]);
        e.r   = rv;
        e.neg = !rv[8] && (m != 0);
        e.h   = 4'(m / 100);
        e.t   = 4'((m / 10) % 10);
        e.o   = 4'(m % 10);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        if (reset_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk($sformatf("neg r=%03h", e.r), 32'(neg), 32'(e.neg));
                chk($sformatf("hundreds r=%03h", e.r), 32'(hundreds), 32'(e.h));
                chk($sformatf("tens r=%03h", e.r), 32'(tens), 32'(e.t));
                chk($sformatf("ones r=%03h", e.r), 32'(ones), 32'(e.o));
            end
        end
    end

    // One conversion from IDLE: r changes to r2 right after the accepting
    // edge, outputs must hold until done, latency and busy length checked.
    task automatic run_conv(input logic [8:0] rv, input logic [8:0] r2, input vec_t e);
        logic [12:0] old;
        int lat;
        int busy_n;
        @(negedge clock);
        old   = {neg, hundreds, tens, ones};
        start = 1'b1;
        r     = rv;
        sb.push_back(e);
        @(negedge clock);
        #1;
        start  = 1'b0;
        r      = r2;
        lat    = 0;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            chk($sformatf("hold r=%03h", rv), 32'({neg, hundreds, tens, ones}), 32'(old));
            @(negedge clock);
            #1;
            lat++;
        end
        chk($sformatf("latency r=%03h", rv), 32'(lat), 32'd9);
        chk($sformatf("busy_cycles r=%03h", rv), 32'(busy_n), 32'd9);
        chk("busy_at_done", 32'(busy), 32'd0);
        @(negedge clock);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        vec_t tbl[9];
        int   base;
        int   idx;
        int   nd;
        int   dt[3];

        tbl[0] = '{9'h1FE, 1'b0, 4'd2, 4'd5, 4'd4};
        tbl[1] = '{9'h005, 1'b1, 4'd0, 4'd0, 4'd5};
        tbl[2] = '{9'h100, 1'b0, 4'd0, 4'd0, 4'd0};
        tbl[3] = '{9'h000, 1'b0, 4'd0, 4'd0, 4'd0};
        tbl[4] = '{9'h1FF, 1'b0, 4'd2, 4'd5, 4'd5};
        tbl[5] = '{9'h0FF, 1'b1, 4'd2, 4'd5, 4'd5};
        tbl[6] = '{9'h1C8, 1'b0, 4'd2, 4'd0, 4'd0};
        tbl[7] = '{9'h163, 1'b0, 4'd0, 4'd9, 4'd9};
        tbl[8] = '{9'h07F, 1'b1, 4'd1, 4'd2, 4'd7};

        reset_n = 1'b0;
        start   = 1'b0;
        r       = 9'h0;
        #22;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_outputs", 32'({neg, hundreds, tens, ones}), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Table vectors.
        for (int i = 0; i < 9; i++) begin
            run_conv(tbl[i].r, tbl[i].r, tbl[i]);
        end

        // Input capture: -127 started, r flips to +255 the next cycle; the
        // previous result (+254) must hold until the load edge.
        run_conv(9'h1FE, 9'h1FE, tbl[0]);
        run_conv(9'h07F, 9'h1FF, tbl[8]);

        // start held high: back-to-back conversions, done every 10 cycles.
        for (int k = 0; k < 3; k++) sb.push_back(tbl[6]);
        @(negedge clock);
        start = 1'b1;
        r     = 9'h1C8;
        idx   = 0;
        nd    = 0;
        while (nd < 3 && idx < 60) begin
            @(negedge clock);
            #1;
            idx++;
            if (done) begin
                dt[nd] = idx;
                nd++;
                if (nd == 3) start = 1'b0;
            end
        end
        chk("b2b_done_count", 32'(nd), 32'd3);
        chk("b2b_interval1", 32'(dt[1] - dt[0]), 32'd10);
        chk("b2b_interval2", 32'(dt[2] - dt[1]), 32'd10);
        base = done_cnt;
        repeat (15) @(negedge clock);
        chk("b2b_no_extra", 32'(done_cnt - base), 32'd0);

        // start pulse mid-SHIFT is ignored.
        base = done_cnt;
        sb.push_back(tbl[4]);
        @(negedge clock);
        start = 1'b1;
        r     = 9'h1FF;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        start = 1'b1;
        r     = 9'h005;
        @(negedge clock);
        start = 1'b0;
        repeat (20) @(negedge clock);
        chk("midshift_single_done", 32'(done_cnt - base), 32'd1);

        // Reset during the 4th SHIFT cycle of +99.
        run_conv(9'h1C8, 9'h1C8, tbl[6]);
        @(negedge clock);
        start = 1'b1;
        r     = 9'h163;
        sb.push_back(tbl[7]);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_outputs", 32'({neg, hundreds, tens, ones}), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        base = done_cnt;
        repeat (12) @(negedge clock);
        chk("midrst_no_done", 32'(done_cnt - base), 32'd0);
        run_conv(9'h163, 9'h163, tbl[7]);

        // Exhaustive sweep, with r scrambled after each accepting edge.
        for (int i = 0; i < 512; i++) begin
            run_conv(9'(i), 9'($urandom), model(9'(i)));
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
